// File: rtl/text_console_ctrl_pkg.sv
// Shared types and constants for the text console controller.
// Contents: geometry widths, state and cursor-operation enums, ASCII control
// codes, the {ascii, rgb} cell payload and small helpers.
package text_console_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned ROW_W  = 6;
  localparam int unsigned COL_W  = 7;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLR_ROW,
    CLR_SCREEN
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_HOME,
    CUR_BACK,
    CUR_RETURN
  } cursor_op_t;

  typedef struct packed {
    logic [7:0]  ascii;
    logic [23:0] rgb;
  } cell_t;

  // Build one character-buffer cell.
  function automatic cell_t pack_cell(input logic [7:0] ascii, input logic [23:0] rgb);
    cell_t c;
    c.ascii = ascii;
    c.rgb   = rgb;
    return c;
  endfunction

  // Printable range 0x20..0x7E.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Character stream handshake between a producer and the console controller.
// Signals: ch_valid, ch_data[7:0] (ASCII), ch_rgb[23:0] (colour), ch_ready.
// Modports: master = character producer, slave = console controller.
interface text_console_ctrl_if;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic [23:0] ch_rgb;
  logic        ch_ready;

  modport master (output ch_valid, ch_data, ch_rgb, input ch_ready);
  modport slave  (input ch_valid, ch_data, ch_rgb, output ch_ready);
endinterface

// File: rtl/text_console_ctrl_cursor.sv
// text_cursor: holds the console cursor and derives its buffer address.
// Ports: clk, rst (async, active-low), op (cursor operation applied on the
// clock edge), row/col (registered cursor), addr (row*COLS+col),
// next_row_base (first cell of the row below, wrapping), at_last_col.
module text_cursor
  import text_console_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  cursor_op_t        op,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_row_base,
  output logic              at_last_col
);

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  logic [ADDR_W-1:0] row_base;
  logic [ROW_W-1:0]  next_row;

  assign row_base      = ADDR_W'(row) * ROW_STEP;
  assign addr          = row_base + ADDR_W'(col);
  assign at_last_col   = (col == LAST_COL);
  assign next_row      = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
  // Base of the following row without a second multiply.
  assign next_row_base = (row == LAST_ROW) ? '0 : row_base + ROW_STEP;

  // Cursor register update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (at_last_col) begin
            col <= '0;
            row <= next_row;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        CUR_NEWLINE: begin
          col <= '0;
          row <= next_row;
        end
        CUR_HOME: begin
          col <= '0;
          row <= '0;
        end
        CUR_BACK: begin
          if (col != '0) col <= col - COL_W'(1);
        end
        CUR_RETURN: col <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: terminal-style sequencer feeding the ASCII character
// buffer write port. Consumes a valid/ready character stream, keeps a cursor
// and emits one-cycle cell writes, including row-clear and screen-clear sweeps.
// Ports: clk, rst (async, active-low), ch (character stream, slave side),
// clear_req (level full-screen clear), busy, ascii_write_en, ascii_input
// {ascii, rgb}, ascii_write_address, cursor_row, cursor_col.
// Build option: define CLEAR_ON_RESET_EN to sweep the screen after reset.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 60,
  parameter logic [23:0] BLANK_RGB = 24'h000000
) (
  input  logic                clk,
  input  logic                rst,
  text_console_ctrl_if.slave  ch,
  input  logic                clear_req,
  output logic                busy,
  output logic                ascii_write_en,
  output logic [31:0]         ascii_input,
  output logic [ADDR_W-1:0]   ascii_write_address,
  output logic [ROW_W-1:0]    cursor_row,
  output logic [COL_W-1:0]    cursor_col
);

  localparam int unsigned       CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(COLS - 1);
  localparam cell_t             BLANK     = pack_cell(ASCII_SPACE, BLANK_RGB);

  if (COLS == 0 || ROWS == 0 || COLS > 128 || ROWS > 64 || CELLS > 8192) begin : g_bad_geometry
    $error("text_console_ctrl: COLS*ROWS must fit the 8192-cell buffer");
  end

  state_t            state;
  logic              wrap;
  logic [ADDR_W-1:0] cnt;
  logic              boot;
  logic              clr_pending;
  logic              accept;
  cursor_op_t        cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_row_base;
  logic              at_last_col;

`ifdef CLEAR_ON_RESET_EN
  // One-cycle pending clear right after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) boot <= 1'b1;
    else      boot <= 1'b0;
  end
`else
  assign boot = 1'b0;
`endif

  assign clr_pending = clear_req || boot;
  assign ch.ch_ready = (state == IDLE) && !clr_pending;
  assign accept      = ch.ch_valid && ch.ch_ready;
  assign busy        = (state != IDLE);

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk           (clk),
    .rst           (rst),
    .op            (cur_op),
    .row           (cursor_row),
    .col           (cursor_col),
    .addr          (cur_addr),
    .next_row_base (next_row_base),
    .at_last_col   (at_last_col)
  );

  // Cursor operation for the current cycle; only IDLE moves the cursor.
  always_comb begin
    cur_op = CUR_NONE;
    if (state == IDLE) begin
      if (clr_pending) begin
        cur_op = CUR_HOME;
      end else if (ch.ch_valid) begin
        if (is_printable(ch.ch_data)) begin
          cur_op = CUR_ADVANCE;
        end else begin
          case (ch.ch_data)
            ASCII_LF: cur_op = CUR_NEWLINE;
            ASCII_CR: cur_op = CUR_RETURN;
            ASCII_BS: cur_op = CUR_BACK;
            ASCII_FF: cur_op = CUR_HOME;
            default:  cur_op = CUR_NONE;
          endcase
        end
      end
    end
  end

  // Sequencer with registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      wrap                <= 1'b0;
      cnt                 <= '0;
      ascii_write_en      <= 1'b0;
      ascii_input         <= '0;
      ascii_write_address <= '0;
    end else begin
      ascii_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_pending || (accept && ch.ch_data == ASCII_FF)) begin
            state               <= CLR_SCREEN;
            ascii_write_en      <= 1'b1;
            ascii_write_address <= '0;
            ascii_input         <= BLANK;
            cnt                 <= LAST_CELL;
          end else if (accept) begin
            if (is_printable(ch.ch_data)) begin
              state               <= WRITE;
              ascii_write_en      <= 1'b1;
              ascii_write_address <= cur_addr;
              ascii_input         <= pack_cell(ch.ch_data, ch.ch_rgb);
              wrap                <= at_last_col;
            end else if (ch.ch_data == ASCII_LF) begin
              // Cursor moves on this edge, so aim at the row below now.
              state               <= CLR_ROW;
              ascii_write_en      <= 1'b1;
              ascii_write_address <= next_row_base;
              ascii_input         <= BLANK;
              cnt                 <= ROW_LAST;
            end else if (ch.ch_data == ASCII_BS && cursor_col != '0) begin
              state               <= WRITE;
              ascii_write_en      <= 1'b1;
              ascii_write_address <= cur_addr - ADDR_W'(1);
              ascii_input         <= BLANK;
              wrap                <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (wrap) begin
            // Cursor already sits at column 0 of the new row.
            state               <= CLR_ROW;
            ascii_write_en      <= 1'b1;
            ascii_write_address <= cur_addr;
            ascii_input         <= BLANK;
            cnt                 <= ROW_LAST;
            wrap                <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        CLR_ROW, CLR_SCREEN: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            ascii_write_en      <= 1'b1;
            ascii_write_address <= ascii_write_address + ADDR_W'(1);
            cnt                 <= cnt - ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: a cursor/cell model predicts every
// buffer write when a character is accepted; a monitor checks each strobe.
module tb_text_console_ctrl;

  localparam int          COLS      = 80;
  localparam int          ROWS      = 60;
  localparam int          CELLS     = COLS * ROWS;
  localparam logic [23:0] BLANK_RGB = 24'h000000;
  localparam logic [31:0] BLANK     = {8'h20, BLANK_RGB};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_req = 1'b0;
  logic        busy;
  logic        ascii_write_en;
  logic [31:0] ascii_input;
  logic [12:0] ascii_write_address;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;

  text_console_ctrl_if ch_if();

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK_RGB(BLANK_RGB)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ch                  (ch_if),
    .clear_req           (clear_req),
    .busy                (busy),
    .ascii_write_en      (ascii_write_en),
    .ascii_input         (ascii_input),
    .ascii_write_address (ascii_write_address),
    .cursor_row          (cursor_row),
    .cursor_col          (cursor_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_row = 0;
  int   m_col = 0;

  function automatic void push_write(input int a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void model_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) push_write(m_row * COLS + i, BLANK);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < CELLS; i++) push_write(i, BLANK);
    m_row = 0;
    m_col = 0;
  endfunction

  // Terminal behaviour of one accepted character.
  function automatic void model_char(input logic [7:0] c, input logic [23:0] rgb);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_write(m_row * COLS + m_col, {c, rgb});
      m_col++;
      if (m_col == COLS) model_newline();
    end else if (c == 8'h0A) begin
      model_newline();
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_write(m_row * COLS + m_col, BLANK);
      end
    end else if (c == 8'h0C) begin
      model_clear();
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Strobe monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst && ascii_write_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got addr %0d data %h, expected no write",
                 ascii_write_address, ascii_input);
      end else begin
        e = exp_q.pop_front();
        if (int'(ascii_write_address) != e.addr || ascii_input !== e.data) begin
          n_err++;
          $display("FAIL strobe: got addr %0d data %h, expected addr %0d data %h",
                   ascii_write_address, ascii_input, e.addr, e.data);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [23:0] rgb);
    int cyc;
    cyc = 0;
    @(negedge clk);
    ch_if.ch_valid = 1'b1;
    ch_if.ch_data  = c;
    ch_if.ch_rgb   = rgb;
    #1;
    while (!ch_if.ch_ready && cyc < 10000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!ch_if.ch_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got ch_ready 0 for %0d cycles, expected 1", cyc);
    end else begin
      model_char(c, rgb);
    end
    @(posedge clk);
    #1 ch_if.ch_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_idle"}, int'(busy), 0);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_row"}, int'(cursor_row), m_row);
    check({tag, "_col"}, int'(cursor_col), m_col);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ch_if.ch_valid = 1'b0;
    clear_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", int'(ascii_write_en), 0);
    check("rst_addr", int'(ascii_write_address), 0);
    check("rst_data", int'(ascii_input), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_row", int'(cursor_row), 0);
    check("rst_col", int'(cursor_col), 0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    rst = 1'b1;
`ifdef CLEAR_ON_RESET_EN
    model_clear();
    wait_idle("boot_clear");
`endif
  endtask

  initial begin
    int cnt;
    logic [7:0] c;
    ch_if.ch_valid = 1'b0;
    ch_if.ch_data  = 8'h00;
    ch_if.ch_rgb   = 24'h0;
    #1;
    do_reset();

    // "Hi" at the home position.
    send(8'h48, 24'hFFFFFF);
    send(8'h69, 24'hFFFFFF);
    wait_idle("hi");
    check("hi_col_abs", int'(cursor_col), 2);

    // LF from (3,5) clears row 4 while ch_ready stays low.
    repeat (3) send(8'h0A, 24'h0);
    repeat (5) send(8'h61, 24'h00FF00);
    wait_idle("pos35");
    send(8'h0A, 24'h0);
    cnt = 0;
    @(negedge clk);
    while (!ch_if.ch_ready && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("lf_ready_low", cnt, 80);
    wait_idle("lf");
    check("lf_row_abs", int'(cursor_row), 4);

    // Full last row, wrapping to row 0.
    send(8'h0C, 24'h0);
    wait_idle("ff");
    repeat (59) send(8'h0A, 24'h0);
    wait_idle("row59");
    for (int i = 0; i < 80; i++) send(8'($urandom_range(32, 126)), 24'($urandom));
    wait_idle("lastrow");

    // Backspace at column 0 and at column 7 of row 2.
    send(8'h0A, 24'h0);
    send(8'h0A, 24'h0);
    send(8'h08, 24'h0);
    wait_idle("bs0");
    repeat (7) send(8'h7A, 24'h0000FF);
    send(8'h08, 24'h0);
    wait_idle("bs7");
    check("bs7_col_abs", int'(cursor_col), 6);

    // clear_req wins over a waiting character.
    @(negedge clk);
    clear_req = 1'b1;
    ch_if.ch_valid = 1'b1;
    ch_if.ch_data  = 8'h41;
    ch_if.ch_rgb   = 24'h123456;
    #1 check("clr_blocks_ready", int'(ch_if.ch_ready), 0);
    model_clear();
    @(posedge clk);
    #1 clear_req = 1'b0;
    send(8'h41, 24'h123456);
    wait_idle("clr_req");

    // Random character mix.
    for (int i = 0; i < 200; i++) begin
      cnt = int'($urandom_range(0, 99));
      if (cnt < 60)      c = 8'($urandom_range(32, 126));
      else if (cnt < 70) c = 8'h0A;
      else if (cnt < 78) c = 8'h0D;
      else if (cnt < 90) c = 8'h08;
      else if (cnt < 91) c = 8'h0C;
      else               c = 8'($urandom_range(127, 255));
      send(c, 24'($urandom));
      check("rand_row", int'(cursor_row), m_row);
      check("rand_col", int'(cursor_col), m_col);
    end
    wait_idle("random");

    // Reset in the middle of a screen clear.
    send(8'h0C, 24'h0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(ascii_write_en && ascii_write_address == 13'd1000) && cnt < 6000);
    check("sweep_reached_1000", int'(ascii_write_address), 1000);
    #1 rst = 1'b0;
    #1;
    check("midrst_we", int'(ascii_write_en), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_row", int'(cursor_row), 0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    rst = 1'b1;
`ifdef CLEAR_ON_RESET_EN
    model_clear();
    wait_idle("midrst_boot");
`endif
    send(8'h5A, 24'hABCDEF);
    wait_idle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
Terminal-style sequencer for the ASCII character-buffer write port: {ascii[7:0], rgb[23:0]} data, 13-bit cell address, 1-cycle write strobe. Accepts a valid/ready character stream and maintains a cursor. Turns printable characters and control codes into buffer writes, including multi-cycle row-clear and screen-clear sweeps. Sits between the character producers (string printer, CPU debug path) and the ascii_master_controller write inputs.

Parameters:
COLS, 80, characters per row
ROWS, 60, rows per screen; COLS*ROWS <= 8192 (checked at elaboration)
BLANK_RGB, 24'h000000, colour written with spaces during clears and backspace

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
ch_valid  in  1  character available
ch_data  in  8  ASCII code
ch_rgb  in  24  colour for a printable character
ch_ready  out  1  controller can accept a character this cycle
clear_req  in  1  level request for a full-screen clear
busy  out  1  controller is in a clear sweep or a write cycle
ascii_write_en  out  1  buffer write strobe
ascii_input  out  32  {ascii, rgb} cell data
ascii_write_address  out  13  cell address = row*COLS+col
cursor_row  out  6  current row
cursor_col  out  7  current column

Behaviour:
- Reset: all outputs 0, cursor (0,0), state IDLE. Reset mid-sweep aborts immediately; partially cleared cells are left as they are.
- States:
  - IDLE: ch_ready=1, busy=0.
  - WRITE: one cycle.
  - CLR_ROW: COLS cycles.
  - CLR_SCREEN: COLS*ROWS cycles.
- Handshake: a transfer occurs on a clock edge where ch_valid && ch_ready. ch_ready is 0 outside IDLE.
- clear_req has priority. If it is high in IDLE, ch_ready is driven 0 that cycle and the controller goes to CLR_SCREEN.
- All write outputs are registered. Accept at edge N gives ascii_write_en=1 during cycle N+1 (exactly 1 cycle per cell).
- Printable 0x20-0x7E:
  - Go to WRITE, writing {ch_data, ch_rgb} at the cursor.
  - Then col+1.
  - If col==COLS-1: col=0 and the row advances.
- Row advance: row=(row==ROWS-1)?0:row+1, then go to CLR_ROW, which writes {0x20, BLANK_RGB} across the new row (cols 0..COLS-1, one per cycle), then returns to IDLE.
- 0x0A LF: col=0, row advance (CLR_ROW). The LF itself performs no write.
- 0x0D CR: col=0, no write, stays in IDLE (ready again next cycle).
- 0x08 BS:
  - If col>0: col-1, then WRITE a blank at the new position.
  - If col==0: no-op.
- 0x0C FF: same as clear_req.
- Any other code: consumed and ignored.
- CLR_SCREEN:
  - Writes the blank cell to addresses 0..COLS*ROWS-1 ascending, one per cycle.
  - Cursor is set to (0,0) at entry.
  - Returns to IDLE after the last address.
- Sweeps use an incrementing address counter (no multiplier). WRITE and BS compute row*COLS+col truncated to 13 bits.
- clear_req arriving during a sweep is ignored unless still high on return to IDLE.

Optional Feature:
CLEAR_ON_RESET_EN:
- Defined: on reset release the controller enters CLR_SCREEN (ch_ready=0, busy=1 for COLS*ROWS cycles), then IDLE.
- Undefined: it leaves reset directly in IDLE and the buffer contents are undefined.

Decomposition:
- Package text_console_pkg:
  - state enum (IDLE, WRITE, CLR_ROW, CLR_SCREEN)
  - ASCII constants: ASCII_BS=8'h08, ASCII_LF=8'h0A, ASCII_FF=8'h0C, ASCII_CR=8'h0D, ASCII_SPACE=8'h20
  - cell packing function {ascii, rgb}
- One sub-module, text_cursor:
  - holds row/col
  - provides advance / newline / home / backspace operations
  - outputs the linear address

Test Plan:
1. "Hi" (0x48, 0x69, rgb FFFFFF) after reset → two strobes, one per cell:
   - address 0: data 0x48FFFFFF
   - address 1: data 0x69FFFFFF
   - cursor ends at (0,2).
2. LF at cursor (3,5) → 80 strobes at addresses 320..399 with data 0x20000000; cursor (4,0); ch_ready low for 80 cycles.
3. 80 printable chars from (59,0) → last char written at address 4799, then row wraps to 0 with addresses 0..79 cleared; cursor (0,0).
4. BS at (2,0) → no strobe. BS at (2,7) → blank written at address 166; cursor (2,6).
5. clear_req and ch_valid both high in IDLE → char not accepted; 4800 strobes at 0..4799; char accepted afterwards at address 0.
6. Reset asserted mid-CLR_SCREEN at address 1000 → strobe drops immediately; state IDLE (or a new sweep starting from 0 if CLEAR_ON_RESET_EN is defined).
